// File: rtl/scope_trace_gen.sv
// Oscilloscope trace renderer: captures a triggered window of audio levels into a
// double-buffered RAM and draws it as a continuous waveform against the pixel scan.
module scope_trace_gen #(
    parameter int VIDEO_X_BITWIDTH = 12,
    parameter int VIDEO_Y_BITWIDTH = 11,
    parameter int DEPTH_BITS       = 8,
    parameter int AUTO_TIMEOUT     = 1024
) (
    input  logic                        I_clk_pixel,
    input  logic                        I_reset_n,
    input  logic [15:0]                 audio_in,
    input  logic                        audio_valid,
    input  logic [VIDEO_X_BITWIDTH-1:0] pixX,
    input  logic [VIDEO_Y_BITWIDTH-1:0] pixY,
    input  logic [VIDEO_X_BITWIDTH-1:0] screenWidth,
    input  logic [VIDEO_Y_BITWIDTH-1:0] screenHeight,
    output logic [15:0]                 sample,
    output logic                        capturing
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int YW    = VIDEO_Y_BITWIDTH + 1;
    localparam int XW1   = VIDEO_X_BITWIDTH + 1;
    localparam logic [10:0]           TIMEOUT_LAST = 11'(AUTO_TIMEOUT - 1);
    localparam logic [DEPTH_BITS-1:0] LAST_IDX     = '1;
    localparam logic [15:0]           TRACE_RGB    = 16'hFFE0;
    localparam logic [15:0]           CENTRE_RGB   = 16'h0410;

    typedef enum logic [1:0] {ARMED, CAPTURE, DONE} state_t;

    state_t                state, state_nxt;
    logic                  disp_bank, frame_valid;
    logic [10:0]           timeout_cnt;
    logic                  prev_neg;
    logic [DEPTH_BITS-1:0] wr_idx;
    logic                  wr_en, trigger, swap, frame_start;
    logic [7:0]            mem [2*DEPTH];
    logic                  unused_low_bits;

    // The low audio byte is below the 8-bit display resolution.
    assign unused_low_bits = ^audio_in[7:0];
    assign frame_start     = (pixX == '0) && (pixY == '0);
    assign capturing       = (state == CAPTURE);

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        trigger   = 1'b0;
        swap      = 1'b0;
        unique case (state)
            ARMED: if (audio_valid && ((prev_neg && !audio_in[15]) || timeout_cnt == TIMEOUT_LAST)) begin
                trigger   = 1'b1;
                wr_en     = 1'b1;
                state_nxt = CAPTURE;
            end
            CAPTURE: if (audio_valid) begin
                wr_en = 1'b1;
                if (wr_idx == LAST_IDX) state_nxt = DONE;
            end
            DONE: if (frame_start) begin
                swap      = 1'b1;
                state_nxt = ARMED;
            end
            default: state_nxt = ARMED;
        endcase
    end

    always_ff @(posedge I_clk_pixel or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state       <= ARMED;
            disp_bank   <= 1'b0;
            frame_valid <= 1'b0;
            timeout_cnt <= '0;
            prev_neg    <= 1'b0;
            wr_idx      <= '0;
        end else begin
            state <= state_nxt;
            if (audio_valid) prev_neg <= audio_in[15];
            // wr_idx wraps to zero after the last write, so ARMED always starts at index 0.
            if (wr_en) wr_idx <= wr_idx + 1'b1;
            if (swap) begin
                disp_bank   <= ~disp_bank;
                frame_valid <= 1'b1;
            end
            if (state != ARMED)
                timeout_cnt <= '0;
            else if (audio_valid && !trigger && timeout_cnt != TIMEOUT_LAST)
                timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

    // Stage 1: geometry from the scan position, RAM read of the current column.
    logic [VIDEO_Y_BITWIDTH-1:0] y0;
    logic signed [YW-1:0]        dy;
    logic [DEPTH_BITS-1:0]       col;
    logic                        in_region;
    logic [7:0]                  rd_lvl, row_q;
    logic [DEPTH_BITS-1:0]       col_q;
    logic                        vis_q, first_q;

    assign y0        = (screenHeight - VIDEO_Y_BITWIDTH'(256)) >> 1;
    assign dy        = $signed({1'b0, pixY}) - $signed({1'b0, y0});
    assign col       = pixX[DEPTH_BITS+1:2];
    assign in_region = ({1'b0, pixX} < XW1'(4 * DEPTH)) && (pixX < screenWidth)
                       && !dy[YW-1] && (dy < YW'(256));

    // NOTE: the sample RAM has no reset; a bank is only shown after it has been completely written.
    always_ff @(posedge I_clk_pixel) begin
        if (wr_en) mem[{~disp_bank, wr_idx}] <= {~audio_in[15], audio_in[14:8]};
        rd_lvl <= mem[{disp_bank, col}];
    end

    always_ff @(posedge I_clk_pixel or negedge I_reset_n) begin
        if (!I_reset_n) begin
            vis_q   <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            first_q <= 1'b0;
        end else begin
            vis_q   <= in_region && frame_valid;
            row_q   <= 8'd255 - dy[7:0];
            col_q   <= col;
            first_q <= (pixX == '0);
        end
    end

    // Stage 2: join the previous column's level to the current one and colour the pixel.
    logic [7:0]            prev_q, last_lvl, prev_lvl, lo, hi;
    logic [DEPTH_BITS-1:0] last_col;
    logic [15:0]           colour;

    always_comb begin
        prev_lvl = prev_q;
        if (first_q)                prev_lvl = rd_lvl;
        else if (col_q != last_col) prev_lvl = last_lvl;
        lo     = (prev_lvl < rd_lvl) ? prev_lvl : rd_lvl;
        hi     = (prev_lvl < rd_lvl) ? rd_lvl : prev_lvl;
        colour = 16'h0000;
        if (vis_q) begin
            if (row_q >= lo && row_q <= hi) colour = TRACE_RGB;
            else if (row_q == 8'd128)       colour = CENTRE_RGB;
        end
    end

    always_ff @(posedge I_clk_pixel or negedge I_reset_n) begin
        if (!I_reset_n) begin
            prev_q   <= '0;
            last_lvl <= '0;
            last_col <= '0;
            sample   <= '0;
        end else begin
            prev_q   <= prev_lvl;
            last_lvl <= rd_lvl;
            last_col <= col_q;
            sample   <= colour;
        end
    end
endmodule

// File: tb/tb_scope_trace_gen.sv
// Self-checking bench for scope_trace_gen: constant vector table plus a stream-level
// reference model of trigger search, window capture, bank swap and pixel colouring.
module tb_scope_trace_gen;
    logic        I_clk_pixel = 1'b0;
    logic        I_reset_n;
    logic [15:0] audio_in;
    logic        audio_valid;
    logic [11:0] pixX, screenWidth;
    logic [10:0] pixY, screenHeight;
    logic [15:0] sample;
    logic        capturing;

    scope_trace_gen dut (
        .I_clk_pixel (I_clk_pixel),
        .I_reset_n   (I_reset_n),
        .audio_in    (audio_in),
        .audio_valid (audio_valid),
        .pixX        (pixX),
        .pixY        (pixY),
        .screenWidth (screenWidth),
        .screenHeight(screenHeight),
        .sample      (sample),
        .capturing   (capturing)
    );

    always #5 I_clk_pixel = ~I_clk_pixel;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: every valid sample since reset, the point where arming began,
    // and the levels of the window currently on screen.
    logic [15:0] hist[$];
    int          arm_pos = 0;
    bit          m_fv = 1'b0;
    int          m_disp[256];

    typedef struct {
        int          x;
        int          y;
        logic [15:0] exp;
        string       name;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_clk_pixel);
        #1;
    endtask

    function automatic int lvl(input logic [15:0] s);
        return (int'($signed(s)) + 32768) / 256;
    endfunction

    // Index of the sample that starts the capture after arming, or -1 if none yet.
    function automatic int find_trig();
        for (int j = arm_pos; j < hist.size(); j++) begin
            int pv = (j == 0) ? 0 : int'($signed(hist[j-1]));
            int cv = int'($signed(hist[j]));
            if ((pv < 0 && cv >= 0) || (j - arm_pos == 1023)) return j;
        end
        return -1;
    endfunction

    function automatic bit model_capturing();
        int t = find_trig();
        return (t >= 0) && (hist.size() < t + 256);
    endfunction

    function automatic logic [15:0] model_pix(input int x, input int y);
        int y0 = (int'(screenHeight) - 256) / 2;
        int r, c, cur, pv, lo, hi;
        if (!m_fv || x >= 1024 || x >= int'(screenWidth) || y < y0 || y >= y0 + 256) return 16'h0000;
        r   = 255 - (y - y0);
        c   = x / 4;
        cur = m_disp[c];
        pv  = (c == 0) ? cur : m_disp[c-1];
        lo  = (pv < cur) ? pv : cur;
        hi  = (pv < cur) ? cur : pv;
        if (r >= lo && r <= hi) return 16'hFFE0;
        if (r == 128) return 16'h0410;
        return 16'h0000;
    endfunction

    task automatic model_reset();
        hist.delete();
        arm_pos = 0;
        m_fv    = 1'b0;
    endtask

    task automatic send(input logic [15:0] s);
        audio_in    = s;
        audio_valid = 1'b1;
        tick();
        audio_valid = 1'b0;
        hist.push_back(s);
        check("capturing", {31'b0, capturing}, {31'b0, model_capturing()});
    endtask

    task automatic frame_start();
        int t;
        pixX = '0;
        pixY = '0;
        tick();
        t = find_trig();
        if (t >= 0 && hist.size() >= t + 256) begin
            for (int k = 0; k < 256; k++) m_disp[k] = lvl(hist[t+k]);
            m_fv    = 1'b1;
            arm_pos = hist.size();
        end
        pixX = 12'd5;
        pixY = 11'd5;
    endtask

    // Scan pixels 0..n-1 of row y in order, comparing each two cycles after it is driven.
    task automatic scan(input int y, input int n);
        logic [15:0] expq[$];
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                pixX = 12'(i);
                pixY = 11'(y);
                expq.push_back(model_pix(i, y));
            end
            tick();
            if (i >= 1) check($sformatf("scan_y%0d_x%0d", y, i - 1), {16'b0, sample}, {16'b0, expq.pop_front()});
        end
    endtask

    // Present the previous column first so the pixel sees its true left neighbour.
    task automatic apply_pix(input int x, input int y, input logic [15:0] exp, input string name);
        pixX = 12'((x >= 4) ? x - 4 : 0);
        pixY = 11'(y);
        tick();
        pixX = 12'(x);
        tick();
        tick();
        check(name, {16'b0, sample}, {16'b0, exp});
    endtask

    initial begin
        // Levels alternate 0xF0 (even columns) / 0x10 (odd columns); y0 = 232 for height 720.
        tbl[0]  = '{4,    359, 16'hFFE0, "c1_centre_row_trace"};
        tbl[1]  = '{4,    471, 16'hFFE0, "c1_row_0x10"};
        tbl[2]  = '{4,    247, 16'hFFE0, "c1_row_0xF0"};
        tbl[3]  = '{5,    472, 16'h0000, "c1_row_0x0F"};
        tbl[4]  = '{4,    246, 16'h0000, "c1_row_0xF1"};
        tbl[5]  = '{0,    359, 16'h0410, "c0_centre_line"};
        tbl[6]  = '{2,    247, 16'hFFE0, "c0_own_level"};
        tbl[7]  = '{3,    300, 16'h0000, "c0_background"};
        tbl[8]  = '{1024, 359, 16'h0000, "x_1024_outside"};
        tbl[9]  = '{1023, 359, 16'hFFE0, "x_1023_last_col"};
        tbl[10] = '{8,    231, 16'h0000, "y0_minus_1"};
        tbl[11] = '{8,    487, 16'h0000, "row_r0_below_trace"};
        tbl[12] = '{8,    488, 16'h0000, "y0_plus_256"};
        tbl[13] = '{1020, 471, 16'hFFE0, "c255_row_0x10"};

        I_reset_n    = 1'b0;
        audio_in     = '0;
        audio_valid  = 1'b0;
        pixX         = 12'd5;
        pixY         = 11'd5;
        screenWidth  = 12'd1280;
        screenHeight = 11'd720;
        repeat (3) tick();
        check("reset_sample", {16'b0, sample}, 32'h0);
        check("reset_capturing", {31'b0, capturing}, 32'h0);
        I_reset_n = 1'b1;
        model_reset();
        tick();
        scan(359, 40);

        // Zero-crossing trigger: -1 -> +5 starts the window, index 0 is level 0x80.
        send(16'hFF9C);
        send(16'hFFFF);
        send(16'h0005);
        for (int i = 0; i < 255; i++) send(16'($urandom));
        for (int i = 0; i < 3; i++) send(16'($urandom));
        scan(359, 12);
        frame_start();
        apply_pix(0, 359, 16'hFFE0, "zc_index0_level80");
        apply_pix(0, 360, 16'h0000, "zc_index0_row127");
        for (int i = 0; i < 2; i++) scan(int'($urandom_range(230, 490)), 1030);

        // A new capture must not disturb the displayed bank before the next swap.
        for (int i = 0; i < 100; i++) send(16'($urandom));
        scan(int'($urandom_range(232, 487)), 1030);
        for (int i = 0; i < 1200; i++) send(16'($urandom));
        scan(int'($urandom_range(232, 487)), 1030);
        frame_start();
        for (int i = 0; i < 4; i++) scan(int'($urandom_range(230, 490)), 1030);

        // Continuity pattern: trigger on 0x9000 -> 0x7000 then alternate levels.
        send(16'h9000);
        send(16'h7000);
        for (int k = 1; k < 256; k++) send((k % 2 == 1) ? 16'h9000 : 16'h7000);
        frame_start();
        for (int i = 0; i < 14; i++) apply_pix(tbl[i].x, tbl[i].y, tbl[i].exp, tbl[i].name);

        apply_pix(3, 359, 16'h0410, "latency_before_step");
        pixX = 12'd4;
        tick();
        check("latency_1_cycle", {16'b0, sample}, 32'h0410);
        tick();
        check("latency_2_cycles", {16'b0, sample}, 32'hFFE0);

        // Asynchronous reset in the middle of a capture and a displayed frame.
        send(16'h9000);
        send(16'h1000);
        for (int i = 0; i < 20; i++) send(16'($urandom));
        check("capture_running", {31'b0, capturing}, 32'h1);
        apply_pix(2, 247, 16'hFFE0, "pre_reset_trace");
        #2;
        I_reset_n = 1'b0;
        #1;
        check("async_reset_sample", {16'b0, sample}, 32'h0);
        check("async_reset_capturing", {31'b0, capturing}, 32'h0);
        tick();
        tick();
        I_reset_n = 1'b1;
        model_reset();
        scan(247, 16);

        // Auto-trigger on a constant +1000; the last write lands on a frame-start cycle.
        for (int i = 0; i < 1278; i++) send(16'd1000);
        pixX = '0;
        pixY = '0;
        send(16'd1000);
        pixX = 12'd5;
        pixY = 11'd5;
        apply_pix(0, 356, 16'h0000, "no_swap_on_entry_cycle");
        frame_start();
        apply_pix(0, 356, 16'hFFE0, "auto_level_0x83");
        apply_pix(0, 355, 16'h0000, "auto_row_0x84");
        apply_pix(0, 359, 16'h0410, "auto_centre_line");
        scan(356, 1030);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
